// File: rtl/w_tile_controller.sv
// w_tile_controller: sequences double-buffered weight tiles for a compute engine.
// Each tile's weights are fetched into a shadow buffer. When the shadow buffer is
// full and the ifmap engine is idle, the active/shadow buffers are swapped and
// compute is launched. The next tile is then prefetched while the current tile
// computes.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a job (sampled only when idle)
//   num_tiles  tiles in the job (captured on an accepted start)
//   abort      synchronous job cancel
//   w_done     shadow weight buffer full (level, cleared by loader after clr_w)
//   if_ready   ifmap engine idle (level)
//   w_read     weight fetch enable
//   clr_w      shadow buffer clear / start of a new tile fetch
//   switch     active/shadow buffer swap
//   start_if   compute launch (always coincident with switch)
//   ready      controller idle
//   busy       job in progress
//   done       one-cycle job-complete pulse (registered)
//   tile_idx   index of the tile being fetched (registered)
module w_tile_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tiles,
  input  logic             abort,
  input  logic             w_done,
  input  logic             if_ready,
  output logic             w_read,
  output logic             clr_w,
  output logic             switch,
  output logic             start_if,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tile_idx
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tile_idx_q, tile_idx_d;
  logic [CNT_W-1:0] num_tiles_q, num_tiles_d;
  logic             done_q, done_d;
  // guard_q: first FETCH cycle after clr_w; w_done may still be stale from the
  // previous tile because the loader clears it one cycle late.
  logic             guard_q, guard_d;
  // drain_first_q: first DRAIN cycle, where if_ready may still reflect the idle
  // engine from before the final start_if.
  logic             drain_first_q, drain_first_d;
  logic             last_tile;

  assign last_tile = (tile_idx_q == (num_tiles_q - One));
  assign tile_idx  = tile_idx_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tile_idx_q    <= '0;
      num_tiles_q   <= '0;
      done_q        <= 1'b0;
      guard_q       <= 1'b0;
      drain_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tile_idx_q    <= tile_idx_d;
      num_tiles_q   <= num_tiles_d;
      done_q        <= done_d;
      guard_q       <= guard_d;
      drain_first_q <= drain_first_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tile_idx_d    = tile_idx_q;
    num_tiles_d   = num_tiles_q;
    done_d        = 1'b0;
    drain_first_d = 1'b0;
    w_read        = 1'b0;
    clr_w         = 1'b0;
    switch        = 1'b0;
    start_if      = 1'b0;
    ready         = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        // abort does nothing here except veto a simultaneous start
        if (start && !abort) begin
          if (num_tiles != '0) begin
            w_read      = 1'b1;
            clr_w       = 1'b1;
            num_tiles_d = num_tiles;
            tile_idx_d  = '0;
            state_d     = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StFetch, StWait: begin
        busy = 1'b1;
        if (abort) begin
          state_d    = StIdle;
          tile_idx_d = '0;
        end else if (state_q == StFetch && (guard_q || !w_done)) begin
          w_read = 1'b1;
        end else if (if_ready) begin
          // switch cycle: swap buffers, launch compute, prefetch the next tile
          switch   = 1'b1;
          start_if = 1'b1;
          if (!last_tile) begin
            clr_w      = 1'b1;
            tile_idx_d = tile_idx_q + One;
            state_d    = StFetch;
          end else begin
            drain_first_d = 1'b1;
            state_d       = StDrain;
          end
        end else begin
          state_d = StWait;
        end
      end

      StDrain: begin
        busy = 1'b1;
        if (abort) begin
          state_d    = StIdle;
          tile_idx_d = '0;
        end else if (!drain_first_q && if_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    guard_d = clr_w;

    // Strobes must be quiet while reset is held, even if start is high.
    if (rst) begin
      w_read   = 1'b0;
      clr_w    = 1'b0;
      switch   = 1'b0;
      start_if = 1'b0;
      busy     = 1'b0;
      ready    = 1'b1;
    end
  end

endmodule

// File: doc/w_tile_controller.md
W_TILE_CONTROLLER -- requirements
Module: w_tile_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the tile counter and tile-count width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a job; sampled only in IDLE.
REQ-005 The block SHALL have port num_tiles, input, CNT_W, tiles in the job; captured on an accepted start.
REQ-006 The block SHALL have port abort, input, 1, synchronous job cancel.
REQ-007 The block SHALL have port w_done, input, 1, level from the weight loader meaning the shadow weight buffer is full; the loader clears it within 1 cycle of clr_w.
REQ-008 The block SHALL have port if_ready, input, 1, level meaning the ifmap engine is idle and can accept start_if.
REQ-009 The block SHALL have outputs w_read, clr_w, switch and start_if, each 1 bit: fetch enable, shadow-buffer clear, active/shadow swap, and compute launch.
REQ-010 The block SHALL have outputs ready (1), busy (1), done (1) and tile_idx (CNT_W): idle indication, job in progress, one-cycle job-complete pulse, and index of the tile being fetched.

Function
REQ-011 States SHALL be IDLE, FETCH, WAIT and DRAIN, with a 2-bit encoding; any illegal encoding SHALL go to IDLE next cycle with all outputs 0.
REQ-012 w_read, clr_w, switch, start_if, ready and busy SHALL be combinational decodes of state and inputs; tile_idx, num_tiles_q, done and the guard flag SHALL be registered.
REQ-013 In IDLE: ready=1 and busy=0.
REQ-014 In IDLE, start=1 with num_tiles!=0 SHALL, in the same cycle, assert w_read=1 and clr_w=1, capture num_tiles_q, set tile_idx<=0, and move to FETCH.
REQ-015 In IDLE, start=1 with num_tiles==0 SHALL pulse done for 1 cycle (next cycle) and stay in IDLE.
REQ-016 In FETCH: w_read=1 while w_done=0.
REQ-017 In the first FETCH cycle after any clr_w, the guard flag SHALL cause w_done to be ignored, with w_read held at 1.
REQ-018 The switch cycle is defined as FETCH with w_done=1 and if_ready=1, or WAIT with if_ready=1.
REQ-019 In every switch cycle: switch=1, start_if=1, w_read=0.
REQ-020 In a switch cycle where tile_idx != num_tiles_q-1: clr_w=1, tile_idx<=tile_idx+1 (no wrap is possible), and next state is FETCH, so the next tile is prefetched while the current tile computes.
REQ-021 In a switch cycle where tile_idx == num_tiles_q-1: clr_w=0 and next state is DRAIN.
REQ-022 FETCH with w_done=1 and if_ready=0 SHALL go to WAIT with w_read=0.
REQ-023 WAIT with if_ready=0 SHALL hold with all strobes 0.
REQ-024 DRAIN SHALL ignore if_ready in its first cycle.
REQ-025 From the second DRAIN cycle, if_ready=1 SHALL go to IDLE and pulse done for 1 cycle (registered, visible the cycle IDLE is entered).
REQ-026 busy SHALL be 1 in FETCH, WAIT and DRAIN.
REQ-027 abort=1 in any non-IDLE state SHALL take priority over all other transitions.
REQ-028 On abort: go to IDLE next cycle, drive no switch, start_if or clr_w in that cycle, hold done=0, and set tile_idx<=0.
REQ-029 abort in IDLE SHALL have no effect, and abort has priority over a simultaneous start.
REQ-030 switch and start_if SHALL always be asserted together, and each SHALL be high for exactly 1 cycle per tile.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, tile_idx=0, num_tiles_q=0, done=0, guard flag cleared.
REQ-032 While rst=1: ready=1, and busy, w_read, clr_w, switch and start_if are 0.
REQ-033 rst asserted mid-job SHALL abandon the job with no done pulse.
REQ-034 The first edge after rst deasserts SHALL see state IDLE.

Verification
REQ-035 Scenario: num_tiles=3, w_done 4 cycles after each clr_w, if_ready returns 6 cycles after each start_if -> 3 switch/start_if pulses, tile_idx 0,1,2, 2 clr_w after start, then done pulse once and ready=1.
REQ-036 Scenario: num_tiles=1, if_ready held 1 -> start_if once, no second clr_w, DRAIN at least 2 cycles, done pulse.
REQ-037 Scenario: num_tiles=0 -> done pulse on the next cycle, w_read never asserted, busy stays 0.
REQ-038 Scenario: num_tiles=2, w_done high while if_ready=0 for 10 cycles -> WAIT held with w_read=0, then switch in the cycle if_ready rises.
REQ-039 Scenario: abort during the second FETCH of num_tiles=4 -> IDLE next cycle, no done pulse, tile_idx=0; a new start then runs normally.
REQ-040 Scenario: rst pulsed mid-WAIT with clk stopped -> outputs reach reset values without a clock edge.
